// File: rtl/n64_pi_burst_slave.sv
// N64 PI cartridge-bus slave: latches the multiplexed AD address, prefetches halfwords
// from a backing memory for burst reads, and posts strobe-captured writes to that memory.
module n64_pi_burst_slave #(
    parameter logic [31:0] ADDR_BASE      = 32'h1000_0000,
    parameter int          ADDR_SPAN_LOG2 = 26,
    parameter int          MEM_AW         = ADDR_SPAN_LOG2 - 1,
    parameter int          SYNC_STAGES    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       n64_ad_in,
    output logic [15:0]       n64_ad_out,
    output logic              n64_ad_oe,
    input  logic              n64_ale_h,
    input  logic              n64_ale_l,
    input  logic              n64_read_n,
    input  logic              n64_write_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              rd_underrun,
    output logic              busy
);

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {IDLE, PREFETCH, READY, DRIVE, WR_REQ, DRAIN} state_e;

    // Strobe chain carries one extra flop so the last two synchronised samples can be compared.
    logic [NS:0][3:0]    strb_sync_q;
    logic [NS-1:0][15:0] ad_sync_q;

    logic [3:0]  strb_now;
    logic [3:0]  strb_prev;
    logic [15:0] ad_s;
    logic        ale_h_fall;
    logic        ale_l_fall;
    logic        ale_l_rise;
    logic        read_fall;
    logic        read_rise;
    logic        write_fall;
    logic        write_rise;

    state_e            state_q;
    logic [31:0]       addr_q;
    logic              hit_q;
    logic              pend_q;
    logic [15:0]       data_q;
    logic [15:0]       out_q;
    logic              oe_q;
    logic              req_q;
    logic              we_q;
    logic [MEM_AW-1:0] maddr_q;
    logic [15:0]       wdata_q;
    logic              underrun_q;
    logic              wr_armed_q;
    logic              wr_pend_q;
    logic [15:0]       wr_data_q;
    logic [MEM_AW-1:0] wr_maddr_q;

    logic [31:0] addr_lo_d;
    logic [31:0] addr_inc_d;
    logic        hit_lo_d;
    logic        hit_inc_d;

    function automatic logic addr_hit(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return (a >= ADDR_BASE) && ((off >> ADDR_SPAN_LOG2) == 32'd0);
    endfunction

    function automatic logic [MEM_AW-1:0] half_addr(input logic [31:0] a);
        return MEM_AW'((a - ADDR_BASE) >> 1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strb_sync_q <= '1;
            ad_sync_q   <= '0;
        end else begin
            strb_sync_q <= {strb_sync_q[NS-1:0], {n64_ale_h, n64_ale_l, n64_read_n, n64_write_n}};
            ad_sync_q   <= {ad_sync_q[NS-2:0], n64_ad_in};
        end
    end

    assign strb_now   = strb_sync_q[NS-1];
    assign strb_prev  = strb_sync_q[NS];
    assign ad_s       = ad_sync_q[NS-1];
    assign ale_h_fall = strb_prev[3] & ~strb_now[3];
    assign ale_l_fall = strb_prev[2] & ~strb_now[2];
    assign ale_l_rise = ~strb_prev[2] & strb_now[2];
    assign read_fall  = strb_prev[1] & ~strb_now[1];
    assign read_rise  = ~strb_prev[1] & strb_now[1];
    assign write_fall = strb_prev[0] & ~strb_now[0];
    assign write_rise = ~strb_prev[0] & strb_now[0];

    assign addr_lo_d  = {addr_q[31:16], ad_s};
    assign addr_inc_d = addr_q + 32'd2;
    assign hit_lo_d   = addr_hit(addr_lo_d);
    assign hit_inc_d  = addr_hit(addr_inc_d);

    // pend_q remembers a hit prefetch that must wait until the memory side is free again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            hit_q      <= 1'b0;
            pend_q     <= 1'b0;
            data_q     <= '0;
            out_q      <= '0;
            oe_q       <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            maddr_q    <= '0;
            wdata_q    <= '0;
            underrun_q <= 1'b0;
            wr_armed_q <= 1'b0;
            wr_pend_q  <= 1'b0;
            wr_data_q  <= '0;
            wr_maddr_q <= '0;
        end else begin
            if (ale_h_fall) begin
                addr_q[31:16] <= ad_s;
            end
            if (ale_l_fall) begin
                addr_q[15:0] <= ad_s;
                hit_q        <= hit_lo_d;
                pend_q       <= hit_lo_d;
            end
            if (write_fall) begin
                wr_armed_q <= !read_fall;
            end

            if (ale_l_rise) begin
                hit_q  <= 1'b0;
                oe_q   <= 1'b0;
                pend_q <= 1'b0;
                if (req_q && !mem_ack) begin
                    state_q <= DRAIN;
                end else begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (wr_pend_q) begin
                            req_q     <= 1'b1;
                            we_q      <= 1'b1;
                            maddr_q   <= wr_maddr_q;
                            wdata_q   <= wr_data_q;
                            wr_pend_q <= 1'b0;
                            state_q   <= WR_REQ;
                        end else if ((ale_l_fall && hit_lo_d) || pend_q) begin
                            req_q   <= 1'b1;
                            we_q    <= 1'b0;
                            maddr_q <= ale_l_fall ? half_addr(addr_lo_d) : half_addr(addr_q);
                            pend_q  <= 1'b0;
                            state_q <= PREFETCH;
                        end
                    end
                    PREFETCH: begin
                        if (read_fall) begin
                            oe_q    <= 1'b1;
                            state_q <= DRIVE;
                            if (mem_ack) begin
                                out_q  <= mem_rdata;
                                data_q <= mem_rdata;
                                req_q  <= 1'b0;
                            end else begin
                                out_q      <= '0;
                                underrun_q <= 1'b1;
                            end
                        end else if (mem_ack) begin
                            data_q  <= mem_rdata;
                            req_q   <= 1'b0;
                            state_q <= READY;
                        end
                    end
                    READY: begin
                        if (read_fall) begin
                            oe_q    <= 1'b1;
                            out_q   <= data_q;
                            state_q <= DRIVE;
                        end else if (wr_pend_q) begin
                            req_q     <= 1'b1;
                            we_q      <= 1'b1;
                            maddr_q   <= wr_maddr_q;
                            wdata_q   <= wr_data_q;
                            wr_pend_q <= 1'b0;
                            state_q   <= WR_REQ;
                        end
                    end
                    DRIVE: begin
                        // A late prefetch landing here replaces the zero driven after an underrun.
                        if (req_q && mem_ack) begin
                            out_q  <= mem_rdata;
                            data_q <= mem_rdata;
                            req_q  <= 1'b0;
                        end
                        if (read_rise) begin
                            oe_q   <= 1'b0;
                            addr_q <= addr_inc_d;
                            hit_q  <= hit_inc_d;
                            if (req_q) begin
                                pend_q  <= hit_inc_d;
                                state_q <= mem_ack ? IDLE : DRAIN;
                            end else if (hit_inc_d) begin
                                req_q   <= 1'b1;
                                we_q    <= 1'b0;
                                maddr_q <= half_addr(addr_inc_d);
                                state_q <= PREFETCH;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    WR_REQ: begin
                        if (mem_ack) begin
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    DRAIN: begin
                        if (mem_ack) begin
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end

            // Writes are captured into a holding slot so an in-flight read keeps its request stable.
            if (write_rise && wr_armed_q) begin
                wr_armed_q <= 1'b0;
                if (hit_q) begin
                    wr_pend_q  <= 1'b1;
                    wr_data_q  <= ad_s;
                    wr_maddr_q <= half_addr(addr_q);
                    addr_q     <= addr_inc_d;
                end
            end
        end
    end

    assign n64_ad_out  = out_q;
    assign n64_ad_oe   = oe_q;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = maddr_q;
    assign mem_wdata   = wdata_q;
    assign rd_underrun = underrun_q;
    assign busy        = (state_q != IDLE);

endmodule
